// File: rtl/multicycle_core_ctrl.sv
// Multicycle instruction sequencer: walks each instruction through fetch, decode, execute,
// memory and writeback, confines architectural writes to writeback and tracks halt causes.
module multicycle_core_ctrl #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_ifu_req,
  input  logic             i_ifu_valid,
  input  logic [XLEN-1:0]  i_inst,
  output logic [XLEN-1:0]  o_inst,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_is_ebreak,
  input  logic             i_illegal,
  output logic             o_lsu_req,
  input  logic             i_lsu_done,
  output logic             o_gpr_we_gate,
  output logic             o_csr_we_gate,
  output logic             o_pc_we,
  output logic             o_retire,
  input  logic             i_step_mode,
  input  logic             i_step_go,
  output logic             o_halt,
  output logic [1:0]       o_halt_cause,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    STEP_WAIT,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_EBREAK,
    CAUSE_ILLEGAL,
    CAUSE_TIMEOUT
  } cause_e;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              store_q, store_d;
  logic              ebreak_q, ebreak_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              waiting;
  logic              expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // A handshake arriving on the expiry cycle is checked first, so it always wins.
  assign waiting = ((state_q == FETCH) && !i_ifu_valid) || ((state_q == MEM) && !i_lsu_done);
  assign expired = TO_EN && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (i_ifu_valid) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d = HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        if (i_illegal) begin
          state_d = HALT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC:   state_d = (i_is_load || i_is_store) ? MEM : WB;
      MEM: begin
        if (i_lsu_done) begin
          state_d = WB;
        end else if (expired) begin
          state_d = HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        if (ebreak_q) begin
          state_d = HALT;
          cause_d = CAUSE_EBREAK;
        end else begin
          state_d = i_step_mode ? STEP_WAIT : FETCH;
        end
      end
      STEP_WAIT: begin
        if (i_step_go || !i_step_mode) state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ifu_req     = 1'b0;
    o_lsu_req     = 1'b0;
    o_gpr_we_gate = 1'b0;
    o_csr_we_gate = 1'b0;
    o_pc_we       = 1'b0;
    o_retire      = 1'b0;
    o_halt        = 1'b0;
    unique case (state_q)
      FETCH: o_ifu_req = 1'b1;
      MEM:   o_lsu_req = 1'b1;
      WB: begin
        o_gpr_we_gate = !store_q;
        o_csr_we_gate = 1'b1;
        o_pc_we       = 1'b1;
        o_retire      = 1'b1;
      end
      HALT:    o_halt = 1'b1;
      default: ;
    endcase
  end

  // Decode flags are captured in EXEC so writeback gating never follows live inputs.
  always_comb begin
    inst_d    = inst_q;
    store_d   = store_q;
    ebreak_d  = ebreak_q;
    to_cnt_d  = '0;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if ((state_q == FETCH) && i_ifu_valid) inst_d = i_inst;
    if (state_q == EXEC) begin
      store_d  = i_is_store;
      ebreak_d = i_is_ebreak;
    end
    if (waiting && (state_d == state_q)) to_cnt_d = to_cnt_q + 1'b1;
    if ((state_q != IDLE) && (state_q != HALT)) cycle_d = cycle_q + 1'b1;
    if (state_q == WB) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= '0;
      store_q   <= 1'b0;
      ebreak_q  <= 1'b0;
      to_cnt_q  <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      inst_q    <= inst_d;
      store_q   <= store_d;
      ebreak_q  <= ebreak_d;
      to_cnt_q  <= to_cnt_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign o_inst        = inst_q;
  assign o_halt_cause  = cause_q;
  assign o_cycle_cnt   = cycle_q;
  assign o_instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Bench for multicycle_core_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a procedural instruction-lifecycle model.
module tb_multicycle_core_ctrl;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifuValid;
  logic [XLEN-1:0]  inst;
  logic             isLoad, isStore, isEbreak, illegal;
  logic             lsuDone, stepMode, stepGo;
  logic             ifuReq, lsuReq, gprGate, csrGate, pcWe, retire, halt;
  logic [XLEN-1:0]  instOut;
  logic [1:0]       haltCause;
  logic [CNT_W-1:0] cycleCnt, instretCnt;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  multicycle_core_ctrl #(
    .XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .o_ifu_req(ifuReq), .i_ifu_valid(ifuValid), .i_inst(inst), .o_inst(instOut),
    .i_is_load(isLoad), .i_is_store(isStore), .i_is_ebreak(isEbreak), .i_illegal(illegal),
    .o_lsu_req(lsuReq), .i_lsu_done(lsuDone),
    .o_gpr_we_gate(gprGate), .o_csr_we_gate(csrGate), .o_pc_we(pcWe), .o_retire(retire),
    .i_step_mode(stepMode), .i_step_go(stepGo),
    .o_halt(halt), .o_halt_cause(haltCause),
    .o_cycle_cnt(cycleCnt), .o_instret_cnt(instretCnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives inputs for the current cycle, then advances to just after the next rising edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [XLEN-1:0] in,
                               input bit ld, input bit st, input bit eb, input bit il,
                               input bit dn, input bit sm, input bit sg);
    rst = r; ifuValid = v; inst = in;
    isLoad = ld; isStore = st; isEbreak = eb; illegal = il;
    lsuDone = dn; stepMode = sm; stepGo = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: follows one instruction at a time through its lifecycle.
  logic [XLEN-1:0] expInst;
  int              modelCycle, modelInstret;
  logic [1:0]      modelCause;
  bit              modelStore;

  task automatic modelStep(input bit eIfu, input bit eLsu, input bit eWb, input bit eGpr,
                           input bit eHalt, input bit active, output bit aborted);
    @(negedge clk);
    checkOutput("ifu_req", 64'(ifuReq), 64'(eIfu));
    checkOutput("lsu_req", 64'(lsuReq), 64'(eLsu));
    checkOutput("gpr_we_gate", 64'(gprGate), 64'(eGpr));
    checkOutput("csr_we_gate", 64'(csrGate), 64'(eWb));
    checkOutput("pc_we", 64'(pcWe), 64'(eWb));
    checkOutput("retire", 64'(retire), 64'(eWb));
    checkOutput("halt", 64'(halt), 64'(eHalt));
    checkOutput("halt_cause", 64'(haltCause), 64'(modelCause));
    checkOutput("inst", 64'(instOut), 64'(expInst));
    checkOutput("cycle_cnt", 64'(cycleCnt), 64'(modelCycle));
    checkOutput("instret_cnt", 64'(instretCnt), 64'(modelInstret));
    if (active) modelCycle = (modelCycle + 1) % CNT_MOD;
    if (eWb) modelInstret = (modelInstret + 1) % CNT_MOD;
    aborted = rst;
  endtask

  task automatic haltUntilReset(input logic [1:0] cause);
    bit ab;
    modelCause = cause;
    forever begin
      modelStep(0, 0, 0, 0, 1, 0, ab);
      if (ab) return;
    end
  endtask

  task automatic runAfterReset();
    bit ab;
    int waits;
    modelStep(0, 0, 0, 0, 0, 0, ab);
    if (ab) return;
    forever begin
      waits = 0;
      forever begin
        modelStep(1, 0, 0, 0, 0, 1, ab);
        if (ab) return;
        if (ifuValid) begin
          expInst = inst;
          break;
        end
        waits++;
        if (TIMEOUT != 0 && waits == TIMEOUT) begin
          haltUntilReset(2'd3);
          return;
        end
      end
      modelStep(0, 0, 0, 0, 0, 1, ab);
      if (ab) return;
      if (illegal) begin
        haltUntilReset(2'd2);
        return;
      end
      modelStep(0, 0, 0, 0, 0, 1, ab);
      if (ab) return;
      modelStore = isStore;
      if (isLoad || isStore) begin
        waits = 0;
        forever begin
          modelStep(0, 1, 0, 0, 0, 1, ab);
          if (ab) return;
          if (lsuDone) break;
          waits++;
          if (TIMEOUT != 0 && waits == TIMEOUT) begin
            haltUntilReset(2'd3);
            return;
          end
        end
      end
      modelStep(0, 0, 1, !modelStore, 0, 1, ab);
      if (ab) return;
      if (isEbreak) begin
        haltUntilReset(2'd1);
        return;
      end
      if (stepMode) begin
        forever begin
          modelStep(0, 0, 0, 0, 0, 1, ab);
          if (ab) return;
          if (stepGo || !stepMode) break;
        end
      end
    end
  endtask

  initial begin
    do @(negedge clk); while (rst !== 1'b1);
    forever begin
      modelCycle   = 0;
      modelInstret = 0;
      modelCause   = 2'd0;
      modelStore   = 1'b0;
      expInst      = '0;
      runAfterReset();
    end
  end

  task automatic randomPhase(input int cycles);
    bit v, dn, sg, r;
    bit ld = 0, st = 0, eb = 0, il = 0, sm = 0;
    int haltCycles = 0;
    int pick;
    for (int c = 0; c < cycles; c++) begin
      if (ifuReq) begin
        pick = $urandom_range(0, 99);
        il = (pick < 4);
        eb = (pick >= 4 && pick < 8);
        ld = (pick >= 8 && pick < 33);
        st = (pick >= 33 && pick < 53);
      end
      if ($urandom_range(0, 19) == 0) sm = !sm;
      v  = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 9) < 4);
      sg = ($urandom_range(0, 9) < 3);
      haltCycles = halt ? haltCycles + 1 : 0;
      r  = ($urandom_range(0, 99) == 0) || (haltCycles > 5);
      applyStimulus(r, v, XLEN'($urandom), ld, st, eb, il, dn, sm, sg);
    end
  endtask

  initial begin
    int seen, count;
    bit done;

    // ALU stream with fetch always ready: one retire per four cycles, counters wrap at 16.
    resetDut();
    for (int k = 1; k <= 65; k++) begin
      applyStimulus(0, 1, XLEN'(32'h0000_0013 + k), 0, 0, 0, 0, 0, 0, 0);
      if (k == 41) begin
        checkOutput("t1_instret_41", 64'(instretCnt), 64'd10);
        checkOutput("t1_cycle_41", 64'(cycleCnt), 64'd8);
      end
      if (k == 61) checkOutput("t1_instret_61", 64'(instretCnt), 64'd15);
      if (k == 65) begin
        checkOutput("t1_instret_wrap", 64'(instretCnt), 64'd0);
        checkOutput("t1_cycle_wrap", 64'(cycleCnt), 64'd0);
      end
    end

    // Load whose memory access completes on its third MEM cycle.
    resetDut();
    seen = 0;
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (lsuReq) seen++;
      if (retire) done = 1;
      applyStimulus(0, !done, 32'h0000_2003, 1, 0, 0, 0, lsuReq && seen == 3, 0, 0);
    end
    checkOutput("t2_retired", 64'(done), 64'd1);
    checkOutput("t2_lsu_cycles", 64'(seen), 64'd3);
    checkOutput("t2_instret", 64'(instretCnt), 64'd1);

    // ebreak retires, then the core stays halted with frozen counters.
    resetDut();
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (retire) done = 1;
      applyStimulus(0, 1, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 0);
    end
    checkOutput("t3_retired", 64'(done), 64'd1);
    count = 0;
    for (int c = 0; c < 100; c++) begin
      if (ifuReq) count++;
      applyStimulus(0, 1, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 0);
    end
    checkOutput("t3_ifu_req_cycles", 64'(count), 64'd0);
    checkOutput("t3_halt", 64'(halt), 64'd1);
    checkOutput("t3_cause", 64'(haltCause), 64'd1);
    checkOutput("t3_instret", 64'(instretCnt), 64'd1);
    checkOutput("t3_cycle", 64'(cycleCnt), 64'd4);

    // Silent IFU: halt with timeout cause after four waiting cycles.
    resetDut();
    seen = 0;
    for (int c = 0; c < 20 && !halt; c++) begin
      if (ifuReq) seen++;
      applyStimulus(0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("t4_fetch_cycles", 64'(seen), 64'd4);
    checkOutput("t4_halt", 64'(halt), 64'd1);
    checkOutput("t4_cause", 64'(haltCause), 64'd3);

    // Valid on the fourth waiting cycle beats the timeout.
    resetDut();
    seen = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (ifuReq) seen++;
      done = ifuReq && (seen == 4);
      applyStimulus(0, done, 32'h00A0_0093, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("t4b_halt", 64'(halt), 64'd0);
    checkOutput("t4b_inst", 64'(instOut), 64'h00A0_0093);
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4b_retire", 64'(retire), 64'd1);

    // Single-step: stall after a retire, one go pulse releases exactly one instruction.
    resetDut();
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (retire) done = 1;
      applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("t5_first_retire", 64'(done), 64'd1);
    count = 0;
    for (int c = 0; c < 10; c++) begin
      if (retire || ifuReq) count++;
      applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("t5_stalled", 64'(count), 64'd0);
    applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 1, 1);
    count = 0;
    for (int c = 0; c < 15; c++) begin
      if (retire) count++;
      applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("t5_step_retires", 64'(count), 64'd1);
    checkOutput("t5_instret", 64'(instretCnt), 64'd2);

    // Reset while a memory access is outstanding.
    resetDut();
    for (int c = 0; c < 20 && !lsuReq; c++) begin
      applyStimulus(0, 1, 32'h0000_2003, 1, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("t6_in_mem", 64'(lsuReq), 64'd1);
    applyStimulus(1, 0, '0, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("t6_lsu_req", 64'(lsuReq), 64'd0);
    checkOutput("t6_ifu_req_idle", 64'(ifuReq), 64'd0);
    checkOutput("t6_cycle", 64'(cycleCnt), 64'd0);
    checkOutput("t6_instret", 64'(instretCnt), 64'd0);
    checkOutput("t6_inst", 64'(instOut), 64'd0);
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t6_fetch", 64'(ifuReq), 64'd1);

    randomPhase(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
